// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared packet layout, port codes and handshake states for the router input stage
package noc_pkg;
    localparam int PKT_W       = 55;
    localparam int ROUTE_HOP_W = 3;
    localparam int ROUTE_MSB   = 54;
    localparam int ROUTE_LSB   = 25;
    localparam int HOP0_LSB    = 52;
    localparam int PKTID_MSB   = 24;
    localparam int PKTID_LSB   = 15;
    localparam int MODID_MSB   = 14;
    localparam int MODID_LSB   = 9;
    localparam int PAYLOAD_MSB = 8;

    localparam logic [ROUTE_HOP_W-1:0] PORT_LOCAL = 3'd0;
    localparam logic [ROUTE_HOP_W-1:0] PORT_N     = 3'd1;
    localparam logic [ROUTE_HOP_W-1:0] PORT_E     = 3'd2;
    localparam logic [ROUTE_HOP_W-1:0] PORT_S     = 3'd3;
    localparam logic [ROUTE_HOP_W-1:0] PORT_W     = 3'd4;

    typedef enum logic [1:0] {
        HS_IDLE,
        HS_GRANT,
        HS_RELEASE
    } hs_state_t;

    function automatic logic port_code_valid(input logic [ROUTE_HOP_W-1:0] code);
        return code <= PORT_W;
    endfunction
endpackage

// File: rtl/noc_sync_fifo.sv
// rtl/noc_sync_fifo.sv - synchronous FIFO with combinational head read and occupancy count
module noc_sync_fifo #(
    parameter int WIDTH = 55,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/local_inport_buffer.sv
// rtl/local_inport_buffer.sv - PE injector handshake, packet FIFO and first-hop decode toward the switch
module local_inport_buffer
    import noc_pkg::*;
#(
    parameter int          DEPTH       = 4,
    parameter int          packetwidth = PKT_W,
    parameter logic [5:0]  routerID    = 6'b000_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ReqUpStr,
    output logic                   GntUpStr,
    output logic                   UpStrFull,
    input  logic [packetwidth-1:0] PacketIn,
    output logic                   OutValid,
    input  logic                   OutReady,
    output logic [2:0]             OutPort,
    output logic [packetwidth-1:0] OutPacket,
    output logic [7:0]             DropCount
);
    localparam int CW = $clog2(DEPTH+1);

    hs_state_t              r_state;
    hs_state_t              w_state_next;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_code_ok;
    logic [packetwidth-1:0] w_head;
    logic [CW-1:0]          w_count;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [2:0]             w_hop;
    logic                   r_full;
    logic [7:0]             r_drop_count;
    logic                   w_unused_router_id;

    noc_sync_fifo #(.WIDTH(packetwidth), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_push),
        .i_data  (PacketIn),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= HS_IDLE;
        else        r_state <= w_state_next;
    end

    // Grant is gated by the registered count, so a same-cycle pop cannot open a slot early
    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            HS_IDLE:    if (ReqUpStr && !w_fifo_full) w_state_next = HS_GRANT;
            HS_GRANT: begin
                w_push       = 1'b1;
                w_state_next = HS_RELEASE;
            end
            HS_RELEASE: if (!ReqUpStr) w_state_next = HS_IDLE;
            default:    w_state_next = HS_IDLE;
        endcase
    end

    assign GntUpStr = (r_state == HS_GRANT);

    assign w_hop     = w_head[packetwidth-1 -: ROUTE_HOP_W];
    assign w_code_ok = port_code_valid(w_hop);
    assign OutValid  = !w_fifo_empty && w_code_ok;
    assign w_drop    = !w_fifo_empty && !w_code_ok;
    assign w_pop     = (OutValid && OutReady) || w_drop;
    assign OutPort   = w_fifo_empty ? 3'b000 : w_hop;
    assign OutPacket = w_fifo_empty ? '0
                     : {w_head[packetwidth-ROUTE_HOP_W-1:ROUTE_LSB], 3'b000, w_head[ROUTE_LSB-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full       <= 1'b0;
            r_drop_count <= 8'd0;
        end else begin
            r_full <= (w_count == CW'(DEPTH));
            if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
        end
    end

    assign UpStrFull = r_full;
    assign DropCount = r_drop_count;

    assign w_unused_router_id = ^routerID;
endmodule

// File: tb/tb_local_inport_buffer.sv
// tb/tb_local_inport_buffer.sv - self-checking bench for local_inport_buffer with a queue-based packet model
module tb_local_inport_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqUpStr;
    logic        GntUpStr;
    logic        UpStrFull;
    logic [54:0] PacketIn;
    logic        OutValid;
    logic        OutReady;
    logic [2:0]  OutPort;
    logic [54:0] OutPacket;
    logic [7:0]  DropCount;

    int n_tests = 0;
    int n_fail  = 0;

    logic [54:0] q[$];
    int          drop_cnt = 0;
    bit          exp_full = 1'b0;

    always #5 clk = ~clk;

    local_inport_buffer #(.DEPTH(DEPTH), .packetwidth(55), .routerID(6'b000_000)) dut (
        .clk       (clk),
        .reset     (reset),
        .ReqUpStr  (ReqUpStr),
        .GntUpStr  (GntUpStr),
        .UpStrFull (UpStrFull),
        .PacketIn  (PacketIn),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutPort   (OutPort),
        .OutPacket (OutPacket),
        .DropCount (DropCount)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [54:0] mk(input logic [2:0] code);
        logic [54:0] p;
        p = {code, 27'($urandom), 25'($urandom)};
        return p;
    endfunction

    // One clock edge: apply the spec's pop/drop/push rules to the model queue
    task automatic step(input bit push);
        int pre;
        logic [54:0] h;
        @(posedge clk);
        if (reset) begin
            pre = q.size();
            if (pre > 0) begin
                h = q[0];
                if (h[54:52] > 3'd4) begin
                    void'(q.pop_front());
                    if (drop_cnt < 255) drop_cnt++;
                end else if (OutReady) begin
                    void'(q.pop_front());
                end
            end
            if (push) q.push_back(PacketIn);
            exp_full = (pre == DEPTH);
        end
        #1;
    endtask

    task automatic check_outputs();
        logic [54:0] h;
        bit ne;
        ne = (q.size() > 0);
        h  = ne ? q[0] : 55'd0;
        chk("out_valid", OutValid, ne && (h[54:52] <= 3'd4));
        chk("out_port", OutPort, ne ? h[54:52] : 3'd0);
        chk("out_packet", OutPacket, ne ? {h[51:25], 3'b000, h[24:0]} : 55'd0);
        chk("full", UpStrFull, exp_full);
        chk("drop_count", DropCount, drop_cnt);
        chk("count", dut.u_fifo.r_count, q.size());
    endtask

    task automatic set_ready(input int v);
        if (v < 0) OutReady = 1'($urandom_range(0, 1));
        else       OutReady = v[0];
    endtask

    // Injector side: request, wait for grant, capture, optionally keep request high, release
    task automatic send(input logic [54:0] pkt, input int hold, input int wait_ready,
                        input int pulse_at, input int ready_cap);
        bit got;
        bit exp_g;
        ReqUpStr = 1'b1;
        PacketIn = pkt;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (pulse_at >= 0) set_ready(n == pulse_at ? 1 : 0);
            else               set_ready(wait_ready);
            exp_g = (q.size() < DEPTH);
            step(1'b0);
            chk("gnt_wait", GntUpStr, exp_g);
            check_outputs();
            got = exp_g;
        end
        if (!got) chk("gnt_timeout", 1'b0, 1'b1);
        set_ready(ready_cap);
        step(1'b1);
        ReqUpStr = (hold > 0);
        chk("gnt_pulse_end", GntUpStr, 1'b0);
        check_outputs();
        for (int h = 0; h < hold; h++) begin
            set_ready(wait_ready);
            step(1'b0);
            chk("gnt_held_req", GntUpStr, 1'b0);
            if (h == hold - 1) ReqUpStr = 1'b0;
        end
        ReqUpStr = 1'b0;
        set_ready(wait_ready);
        step(1'b0);
        check_outputs();
    endtask

    task automatic drain(input int n);
        OutReady = 1'b1;
        for (int i = 0; i < n; i++) begin
            step(1'b0);
            check_outputs();
        end
        OutReady = 1'b0;
    endtask

    initial begin
        logic [54:0] p;
        logic [54:0] second;
        reset    = 1'b0;
        ReqUpStr = 1'b0;
        OutReady = 1'b0;
        PacketIn = '0;
        step(1'b0);
        step(1'b0);
        check_outputs();
        chk("reset_gnt", GntUpStr, 1'b0);
        reset = 1'b1;
        step(1'b0);
        check_outputs();

        // Single packet: hop0 = E, next hop 1 moves up
        p = {30'o2100000000, 10'd1, 6'd0, 9'h167};
        send(p, 0, 0, -1, 0);
        chk("single_port", OutPort, 3'b010);
        chk("single_route", OutPacket[54:25], 30'o1000000000);
        chk("single_valid", OutValid, 1'b1);
        drain(2);

        // Fill to DEPTH, then a fifth request waits for one pop
        for (int i = 0; i < 4; i++) send(mk(3'($urandom_range(0, 4))), 0, 0, -1, 0);
        chk("full_after_4", UpStrFull, 1'b1);
        send(mk(3'd1), 0, 0, 2, 0);
        drain(6);

        // Held request: one capture only
        send(mk(3'd3), 5, 0, -1, 0);
        chk("held_count", dut.u_fifo.r_count, 1);
        drain(2);

        // Push and pop on the same edge with two entries queued
        send(mk(3'd0), 0, 0, -1, 0);
        send(mk(3'd4), 0, 0, -1, 0);
        second = q[1];
        send(mk(3'd2), 0, 0, -1, 1);
        chk("simul_count", dut.u_fifo.r_count, 2);
        chk("simul_order", OutPacket[24:0], second[24:0]);
        drain(4);

        // Randomized traffic including invalid codes
        for (int i = 0; i < 40; i++) send(mk(3'($urandom_range(0, 7))), $urandom_range(0, 2), -1, -1, -1);
        drain(8);

        // Asynchronous reset while the grant is up
        OutReady = 1'b0;
        ReqUpStr = 1'b1;
        PacketIn = mk(3'd2);
        step(1'b0);
        chk("rst_gnt_before", GntUpStr, 1'b1);
        #2 reset = 1'b0;
        q.delete();
        drop_cnt = 0;
        exp_full = 1'b0;
        #1;
        chk("rst_gnt_async", GntUpStr, 1'b0);
        check_outputs();
        ReqUpStr = 1'b0;
        step(1'b0);
        check_outputs();
        reset = 1'b1;
        step(1'b0);
        send(mk(3'd1), 0, 0, -1, 0);
        chk("post_rst_valid", OutValid, 1'b1);
        drain(2);

        // Invalid route code: dropped, counter saturates
        send(mk(3'd7), 0, 0, -1, 0);
        step(1'b0);
        chk("drop_one", DropCount, 8'd1);
        chk("drop_no_valid", OutValid, 1'b0);
        for (int i = 0; i < 255; i++) send(mk(3'($urandom_range(5, 7))), 0, 0, -1, 0);
        step(1'b0);
        check_outputs();
        chk("drop_sat", DropCount, 8'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
